// File: rtl/mdu_hilo_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo_if
// Brief    : EX-stage <-> multiply/divide unit signal bundle (op in, HI/LO out)
// Revision : 1.0  initial release
// ============================================================================
interface mdu_hilo_if;
    logic        flush;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // master: the EX stage / stall side; slave: the MDU itself
    modport master (
        output flush, start, op, rs_data, rt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  flush, start, op, rs_data, rt_data,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo
// Brief    : Iterative multiply/divide unit owning the architectural HI/LO pair
// Revision : 1.0  initial release
// ============================================================================
module mdu_hilo #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic      clk,
    input  logic      rst,
    mdu_hilo_if.slave mdu
);
    localparam logic [2:0] c_op_mult  = 3'b001;
    localparam logic [2:0] c_op_multu = 3'b010;
    localparam logic [2:0] c_op_div   = 3'b011;
    localparam logic [2:0] c_op_divu  = 3'b100;
    localparam logic [2:0] c_op_mthi  = 3'b101;
    localparam logic [2:0] c_op_mtlo  = 3'b110;

    localparam logic [4:0] c_mul_cnt = 5'(MUL_LAT - 1);
    localparam logic [4:0] c_div_cnt = 5'(DIV_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL     = 2'd1,
        S_DIV     = 2'd2,
        S_DIV_FIX = 2'd3
    } state_t;

    state_t      r_state,      w_state_nx;
    logic [4:0]  r_cnt,        w_cnt_nx;
    // r_opa: multiplicand, or dividend magnitude that shifts into the quotient
    logic [31:0] r_opa,        w_opa_nx;
    logic [31:0] r_opb,        w_opb_nx;
    logic [31:0] r_rem,        w_rem_nx;
    logic        r_mul_signed, w_mul_signed_nx;
    logic        r_quo_neg,    w_quo_neg_nx;
    logic        r_rem_neg,    w_rem_neg_nx;
    logic [31:0] r_hi,         w_hi_nx;
    logic [31:0] r_lo,         w_lo_nx;
    logic        r_done,       w_done_nx;

    logic        w_div_signed;
    logic [31:0] w_abs_rs;
    logic [31:0] w_abs_rt;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [32:0] w_trial;
    logic [32:0] w_diff;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // 32-bit unsigned magnitudes keep 0x80000000 intact
    assign w_div_signed = (mdu.op == c_op_div);
    assign w_abs_rs = (w_div_signed && mdu.rs_data[31]) ? (32'd0 - mdu.rs_data) : mdu.rs_data;
    assign w_abs_rt = (w_div_signed && mdu.rt_data[31]) ? (32'd0 - mdu.rt_data) : mdu.rt_data;

    assign w_ext_a = {{32{r_mul_signed & r_opa[31]}}, r_opa};
    assign w_ext_b = {{32{r_mul_signed & r_opb[31]}}, r_opb};
    assign w_prod  = w_ext_a * w_ext_b;

    // One restoring step: 33-bit trial remainder minus divisor, sign bit decides
    assign w_trial = {r_rem, r_opa[31]};
    assign w_diff  = w_trial - {1'b0, r_opb};

    assign w_quo_fix = r_quo_neg ? (32'd0 - r_opa) : r_opa;
    assign w_rem_fix = r_rem_neg ? (32'd0 - r_rem) : r_rem;

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_opa_nx        = r_opa;
        w_opb_nx        = r_opb;
        w_rem_nx        = r_rem;
        w_mul_signed_nx = r_mul_signed;
        w_quo_neg_nx    = r_quo_neg;
        w_rem_neg_nx    = r_rem_neg;
        w_hi_nx         = r_hi;
        w_lo_nx         = r_lo;
        w_done_nx       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (mdu.start && !mdu.flush) begin
                    case (mdu.op)
                        c_op_mult, c_op_multu: begin
                            w_opa_nx        = mdu.rs_data;
                            w_opb_nx        = mdu.rt_data;
                            w_mul_signed_nx = (mdu.op == c_op_mult);
                            w_cnt_nx        = c_mul_cnt;
                            w_state_nx      = S_MUL;
                        end
                        c_op_div, c_op_divu: begin
                            w_opa_nx     = w_abs_rs;
                            w_opb_nx     = w_abs_rt;
                            w_rem_nx     = 32'd0;
                            w_quo_neg_nx = w_div_signed & (mdu.rs_data[31] ^ mdu.rt_data[31]);
                            w_rem_neg_nx = w_div_signed & mdu.rs_data[31];
                            w_cnt_nx     = c_div_cnt;
                            w_state_nx   = S_DIV;
                        end
                        c_op_mthi: w_hi_nx = mdu.rs_data;
                        c_op_mtlo: w_lo_nx = mdu.rs_data;
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                if (mdu.flush) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = 5'd0;
                end else if (r_cnt == 5'd0) begin
                    {w_hi_nx, w_lo_nx} = w_prod;
                    w_state_nx         = S_IDLE;
                    w_done_nx          = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 5'd1;
                end
            end

            S_DIV: begin
                if (mdu.flush) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = 5'd0;
                end else begin
                    if (!w_diff[32]) begin
                        w_rem_nx = w_diff[31:0];
                        w_opa_nx = {r_opa[30:0], 1'b1};
                    end else begin
                        w_rem_nx = w_trial[31:0];
                        w_opa_nx = {r_opa[30:0], 1'b0};
                    end
                    if (r_cnt == 5'd0) begin
                        w_state_nx = S_DIV_FIX;
                    end else begin
                        w_cnt_nx = r_cnt - 5'd1;
                    end
                end
            end

            S_DIV_FIX: begin
                w_state_nx = S_IDLE;
                if (!mdu.flush) begin
                    w_lo_nx   = w_quo_fix;
                    w_hi_nx   = w_rem_fix;
                    w_done_nx = 1'b1;
                end
            end

            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 5'd0;
            r_opa        <= 32'd0;
            r_opb        <= 32'd0;
            r_rem        <= 32'd0;
            r_mul_signed <= 1'b0;
            r_quo_neg    <= 1'b0;
            r_rem_neg    <= 1'b0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_opa        <= w_opa_nx;
            r_opb        <= w_opb_nx;
            r_rem        <= w_rem_nx;
            r_mul_signed <= w_mul_signed_nx;
            r_quo_neg    <= w_quo_neg_nx;
            r_rem_neg    <= w_rem_neg_nx;
            r_hi         <= w_hi_nx;
            r_lo         <= w_lo_nx;
            r_done       <= w_done_nx;
        end
    end

    // busy decodes registered state only, so start never reaches it combinationally
    assign mdu.busy = (r_state != S_IDLE);
    assign mdu.done = r_done;
    assign mdu.hi   = r_hi;
    assign mdu.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_hilo
// Brief    : Self-checking bench for mdu_hilo: vector table, corner sequences,
//            randomized ops against an arithmetic reference model
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_hilo;
    localparam int         c_mul_lat = 2;
    localparam logic [2:0] c_mult    = 3'b001;
    localparam logic [2:0] c_multu   = 3'b010;
    localparam logic [2:0] c_div     = 3'b011;
    localparam logic [2:0] c_divu    = 3'b100;
    localparam logic [2:0] c_mthi    = 3'b101;
    localparam logic [2:0] c_mtlo    = 3'b110;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_hilo_if mif ();

    mdu_hilo #(.MUL_LAT(c_mul_lat), .DIV_ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mif)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    vec_t vecs [9];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Architectural result of one op, from plain 64-bit arithmetic
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output int lat);
        int          ia;
        int          ib;
        longint      sa;
        longint      sb;
        longint      ma;
        longint      mb;
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        ia  = a;
        ib  = b;
        h   = m_hi;
        l   = m_lo;
        lat = 0;
        case (o)
            c_mult: begin
                p   = longint'(ia) * longint'(ib);
                h   = p[63:32];
                l   = p[31:0];
                lat = c_mul_lat;
            end
            c_multu: begin
                p   = {32'd0, a} * {32'd0, b};
                h   = p[63:32];
                l   = p[31:0];
                lat = c_mul_lat;
            end
            c_div, c_divu: begin
                sa = (o == c_div) ? longint'(ia) : longint'({32'd0, a});
                sb = (o == c_div) ? longint'(ib) : longint'({32'd0, b});
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                if (mb == 0) begin
                    q = 32'hFFFF_FFFF;
                    r = ma[31:0];
                end else begin
                    q = 32'(ma / mb);
                    r = 32'(ma % mb);
                end
                l   = ((sa < 0) != (sb < 0)) ? (32'd0 - q) : q;
                h   = (sa < 0) ? (32'd0 - r) : r;
                lat = 33;
            end
            c_mthi: h = a;
            c_mtlo: l = a;
            default: ;
        endcase
    endfunction

    // flush_sel < 0: no flush; otherwise flush in busy cycle (flush_sel % latency),
    // or together with start for ops that never go busy
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int flush_sel, input string tag, output int n_busy);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          lat;
        int          flush_at;
        bit          aborted;
        model(o, a, b, e_hi, e_lo, lat);
        flush_at = (flush_sel < 0) ? -1 : ((lat == 0) ? 0 : (flush_sel % lat));
        aborted  = (flush_at >= 0);
        mif.start   = 1'b1;
        mif.op      = o;
        mif.rs_data = a;
        mif.rt_data = b;
        mif.flush   = aborted && (lat == 0);
        #1;
        chk1({tag, " busy_before_edge"}, mif.busy, 1'b0);
        @(posedge clk); #1;
        mif.start = 1'b0;
        mif.flush = 1'b0;
        n_busy    = 0;
        if (lat > 0) begin
            chk1({tag, " busy_rise"}, mif.busy, 1'b1);
            while (mif.busy && n_busy < 200) begin
                // A competing MTHI during busy must be ignored
                mif.start   = 1'b1;
                mif.op      = c_mthi;
                mif.rs_data = ~a;
                mif.flush   = (n_busy == flush_at);
                @(posedge clk); #1;
                mif.start = 1'b0;
                mif.flush = 1'b0;
                n_busy++;
            end
            chk_int({tag, " busy_cycles"}, n_busy, aborted ? (flush_at + 1) : lat);
        end
        if (!aborted) begin
            m_hi = e_hi;
            m_lo = e_lo;
        end
        chk1({tag, " done"}, mif.done, (lat > 0) && !aborted);
        chk1({tag, " busy_low"}, mif.busy, 1'b0);
        chk32({tag, " hi"}, mif.hi, m_hi);
        chk32({tag, " lo"}, mif.lo, m_lo);
        @(posedge clk); #1;
        chk1({tag, " done_clear"}, mif.done, 1'b0);
        chk32({tag, " hi_stable"}, mif.hi, m_hi);
        chk32({tag, " lo_stable"}, mif.lo, m_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          r_fl;

        vecs[0] = '{c_mult,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2};
        vecs[1] = '{c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2};
        vecs[2] = '{c_div,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3] = '{c_divu,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 33};
        vecs[4] = '{c_div,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[5] = '{c_divu,  32'h0000_0100, 32'h0000_0007, 32'h0000_0004, 32'h0000_0024, 33};
        vecs[6] = '{c_div,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
        vecs[7] = '{c_mult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2};
        vecs[8] = '{c_div,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001, 33};

        rst         = 1'b1;
        mif.flush   = 1'b0;
        mif.start   = 1'b0;
        mif.op      = 3'b000;
        mif.rs_data = 32'd0;
        mif.rt_data = 32'd0;
        m_hi        = 32'd0;
        m_lo        = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk1("reset busy", mif.busy, 1'b0);
        chk1("reset done", mif.done, 1'b0);
        chk32("reset hi", mif.hi, 32'd0);
        chk32("reset lo", mif.lo, 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, -1, $sformatf("vec%0d", i), n);
            chk_int($sformatf("vec%0d table_busy", i), n, vecs[i].exp_busy);
            chk32($sformatf("vec%0d table_hi", i), mif.hi, vecs[i].exp_hi);
            chk32($sformatf("vec%0d table_lo", i), mif.lo, vecs[i].exp_lo);
        end

        // Reset in the tenth busy cycle of a DIV
        mif.start   = 1'b1;
        mif.op      = c_div;
        mif.rs_data = 32'hFFFF_FFF9;
        mif.rt_data = 32'h0000_0002;
        @(posedge clk); #1;
        mif.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk1("rstdiv busy_mid", mif.busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk1("rstdiv busy", mif.busy, 1'b0);
        chk1("rstdiv done", mif.done, 1'b0);
        chk32("rstdiv hi", mif.hi, 32'd0);
        chk32("rstdiv lo", mif.lo, 32'd0);
        @(posedge clk); #1;
        chk1("rstdiv done_after", mif.done, 1'b0);

        do_op(c_mthi, 32'hA5A5_A5A5, 32'd0, -1, "mthi", n);
        chk32("mthi hi_const", mif.hi, 32'hA5A5_A5A5);
        do_op(c_div, 32'd1000, 32'd3, 5, "div_flush", n);
        chk32("div_flush hi_const", mif.hi, 32'hA5A5_A5A5);
        chk32("div_flush lo_const", mif.lo, 32'd0);
        do_op(c_mtlo, 32'h1234_5678, 32'd0, 0, "mtlo_flush", n);
        chk32("mtlo_flush lo_const", mif.lo, 32'd0);
        do_op(c_mult, 32'd3, 32'd5, c_mul_lat - 1, "mul_flush_last", n);
        do_op(c_divu, 32'd9, 32'd4, 32, "div_flush_fix", n);
        do_op(3'b111, 32'hDEAD_BEEF, 32'd1, -1, "noop", n);

        for (int i = 0; i < 60; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = $urandom_range(1, 16);
                default: r_b = $urandom;
            endcase
            r_fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : -1;
            do_op(r_op, r_a, r_b, r_fl, $sformatf("rnd%0d op%0d", i, r_op), n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
